// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit:
// access op/size encodings, bus widths and LSU state encodings.
`ifndef ACCESS_OP_D2R
`define ACCESS_OP_D2R 2'b00
`define ACCESS_OP_M2R 2'b01
`define ACCESS_OP_R2M 2'b10
`endif

`ifndef ACCESS_SZ_BYTE
`define ACCESS_SZ_BYTE  3'd0
`define ACCESS_SZ_HALF  3'd1
`define ACCESS_SZ_WORD  3'd2
`define ACCESS_SZ_LEFT  3'd3
`define ACCESS_SZ_RIGHT 3'd4
`endif

package mem_lsu_pkg;

  localparam int unsigned OP_W   = 2;
  localparam int unsigned SZ_W   = 3;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [OP_W-1:0] OP_D2R = `ACCESS_OP_D2R;
  localparam logic [OP_W-1:0] OP_M2R = `ACCESS_OP_M2R;
  localparam logic [OP_W-1:0] OP_R2M = `ACCESS_OP_R2M;

  localparam logic [SZ_W-1:0] SZ_BYTE  = `ACCESS_SZ_BYTE;
  localparam logic [SZ_W-1:0] SZ_HALF  = `ACCESS_SZ_HALF;
  localparam logic [SZ_W-1:0] SZ_WORD  = `ACCESS_SZ_WORD;
  localparam logic [SZ_W-1:0] SZ_LEFT  = `ACCESS_SZ_LEFT;
  localparam logic [SZ_W-1:0] SZ_RIGHT = `ACCESS_SZ_RIGHT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } lsu_state_e;

  // Byte lane idx of a little-endian word.
  function automatic logic [7:0] lane8(input logic [WORD_W-1:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte enables, store data alignment,
// load extraction/extension/merge and misalignment detection.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [SZ_W-1:0]   size_i,
  input  logic [1:0]        offs_i,
  input  logic [WORD_W-1:0] rt_i,
  input  logic [WORD_W-1:0] rdata_i,
  input  logic              unsigned_i,
  output logic [BE_W-1:0]   be_o,
  output logic [WORD_W-1:0] wrdata_o,
  output logic [WORD_W-1:0] load_o,
  output logic              misaligned_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [4:0]  sh_left;
  logic [4:0]  sh_right;

  assign ld_byte  = lane8(rdata_i, offs_i);
  assign ld_half  = rdata_i[{offs_i[1], 4'b0000} +: 16];
  assign sh_right = {offs_i, 3'b000};
  assign sh_left  = {2'd3 - offs_i, 3'b000};

  always_comb begin
    be_o         = '0;
    wrdata_o     = rt_i;
    load_o       = rdata_i;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o     = 4'b0001 << offs_i;
        wrdata_o = {4{rt_i[7:0]}};
        load_o   = unsigned_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        be_o         = 4'b0011 << offs_i;
        wrdata_o     = {2{rt_i[15:0]}};
        load_o       = unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        misaligned_o = offs_i[0];
      end
      SZ_WORD: begin
        be_o         = 4'hF;
        misaligned_o = |offs_i;
      end
      SZ_LEFT: begin
        // Upper bytes of rt come from memory lanes 0..offs.
        be_o     = 4'b1111 >> (2'd3 - offs_i);
        wrdata_o = rt_i >> sh_left;
        case (offs_i)
          2'd0:    load_o = {rdata_i[7:0],  rt_i[23:0]};
          2'd1:    load_o = {rdata_i[15:0], rt_i[15:0]};
          2'd2:    load_o = {rdata_i[23:0], rt_i[7:0]};
          default: load_o = rdata_i;
        endcase
      end
      SZ_RIGHT: begin
        // Lower bytes of rt come from memory lanes offs..3.
        be_o     = 4'b1111 << offs_i;
        wrdata_o = rt_i << sh_right;
        case (offs_i)
          2'd0:    load_o = rdata_i;
          2'd1:    load_o = {rt_i[31:24], rdata_i[31:8]};
          2'd2:    load_o = {rt_i[31:16], rdata_i[31:16]};
          default: load_o = {rt_i[31:8],  rdata_i[31:24]};
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one req/ack bus transaction per access,
// stalling upstream until the result is available in the DONE cycle.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32  // only 32 is supported
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exception_flush,
  input  logic [OP_W-1:0]   mem_access_op,
  input  logic [SZ_W-1:0]   mem_access_sz,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] data_i,
  input  logic [REG_W-1:0]  reg_addr_i,
  input  logic              flag_unsigned,
  output logic [ADDR_W-1:0] bus_address,
  output logic [BE_W-1:0]   bus_byteenable,
  output logic              bus_read,
  output logic              bus_write,
  output logic [DATA_W-1:0] bus_wrdata,
  input  logic [DATA_W-1:0] bus_rddata,
  input  logic              bus_ack,
  output logic [DATA_W-1:0] data_o,
  output logic [REG_W-1:0]  reg_addr_o,
  output logic              stall,
  output logic              addr_err_load,
  output logic              addr_err_store,
  output logic [ADDR_W-1:0] bad_vaddr
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] bus_address_q, bus_address_d;
  logic [BE_W-1:0]   bus_be_q, bus_be_d;
  logic              bus_read_q, bus_read_d;
  logic              bus_write_q, bus_write_d;
  logic [DATA_W-1:0] bus_wrdata_q, bus_wrdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;

  logic              is_load;
  logic              is_store;
  logic              is_mem;
  logic              misaligned;
  logic              start;
  logic [BE_W-1:0]   al_be;
  logic [DATA_W-1:0] al_wrdata;
  logic [DATA_W-1:0] al_load;

  assign is_load  = (mem_access_op == OP_M2R);
  assign is_store = (mem_access_op == OP_R2M);
  assign is_mem   = is_load | is_store;
  assign start    = (state_q == IDLE) && is_mem && !misaligned && !exception_flush;

  // Load merge uses the buffered bus word and the still-presented rt value.
  mem_lsu_align u_align (
    .size_i       (mem_access_sz),
    .offs_i       (mem_addr[1:0]),
    .rt_i         (data_i),
    .rdata_i      (rbuf_q),
    .unsigned_i   (flag_unsigned),
    .be_o         (al_be),
    .wrdata_o     (al_wrdata),
    .load_o       (al_load),
    .misaligned_o (misaligned)
  );

  // Next-state and bus register updates.
  always_comb begin
    state_d       = state_q;
    bus_address_d = bus_address_q;
    bus_be_d      = bus_be_q;
    bus_read_d    = bus_read_q;
    bus_write_d   = bus_write_q;
    bus_wrdata_d  = bus_wrdata_q;
    rbuf_d        = rbuf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = REQ;
          bus_address_d = {mem_addr[ADDR_W-1:2], 2'b00};
          bus_be_d      = al_be;
          bus_read_d    = is_load;
          bus_write_d   = is_store;
          bus_wrdata_d  = is_store ? al_wrdata : '0;
        end
      end
      REQ: begin
        if (bus_ack) begin
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          if (exception_flush) begin
            state_d = IDLE;
          end else begin
            rbuf_d  = bus_rddata;
            state_d = DONE;
          end
        end else if (exception_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The bus cannot be aborted: hold the request, drop the data.
        if (bus_ack) begin
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          state_d     = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bus_address_q <= '0;
      bus_be_q      <= '0;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_wrdata_q  <= '0;
      rbuf_q        <= '0;
    end else begin
      state_q       <= state_d;
      bus_address_q <= bus_address_d;
      bus_be_q      <= bus_be_d;
      bus_read_q    <= bus_read_d;
      bus_write_q   <= bus_write_d;
      bus_wrdata_q  <= bus_wrdata_d;
      rbuf_q        <= rbuf_d;
    end
  end

  assign bus_address    = bus_address_q;
  assign bus_byteenable = bus_be_q;
  assign bus_read       = bus_read_q;
  assign bus_write      = bus_write_q;
  assign bus_wrdata     = bus_wrdata_q;

  // Pipeline-facing outputs follow the current instruction combinationally.
  always_comb begin
    stall          = 1'b0;
    data_o         = '0;
    reg_addr_o     = '0;
    addr_err_load  = 1'b0;
    addr_err_store = 1'b0;
    bad_vaddr      = '0;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          if (misaligned) begin
            addr_err_load  = is_load;
            addr_err_store = is_store;
            bad_vaddr      = mem_addr;
          end else begin
            stall = !exception_flush;
          end
        end else if (mem_access_op == OP_D2R && !exception_flush) begin
          data_o     = data_i;
          reg_addr_o = reg_addr_i;
        end
      end
      REQ, DRAIN: stall = 1'b1;
      DONE: begin
        if (is_load && !exception_flush) begin
          data_o     = al_load;
          reg_addr_o = reg_addr_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu with a byte-lane reference model and a
// bus responder with programmable ack delay, flush and reset injection.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam logic [31:0] MARK_DATA = 32'hD2D2_D2D2;
  localparam logic [4:0]  MARK_REG  = 5'd30;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception_flush;
  logic [1:0]  mem_access_op;
  logic [2:0]  mem_access_sz;
  logic [31:0] mem_addr;
  logic [31:0] data_i;
  logic [4:0]  reg_addr_i;
  logic        flag_unsigned;
  logic [31:0] bus_address;
  logic [3:0]  bus_byteenable;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_wrdata;
  logic [31:0] bus_rddata;
  logic        bus_ack;
  logic [31:0] data_o;
  logic [4:0]  reg_addr_o;
  logic        stall;
  logic        addr_err_load;
  logic        addr_err_store;
  logic [31:0] bad_vaddr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst(rst), .exception_flush(exception_flush),
    .mem_access_op(mem_access_op), .mem_access_sz(mem_access_sz),
    .mem_addr(mem_addr), .data_i(data_i), .reg_addr_i(reg_addr_i),
    .flag_unsigned(flag_unsigned), .bus_address(bus_address),
    .bus_byteenable(bus_byteenable), .bus_read(bus_read), .bus_write(bus_write),
    .bus_wrdata(bus_wrdata), .bus_rddata(bus_rddata), .bus_ack(bus_ack),
    .data_o(data_o), .reg_addr_o(reg_addr_o), .stall(stall),
    .addr_err_load(addr_err_load), .addr_err_store(addr_err_store),
    .bad_vaddr(bad_vaddr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int byte_of(input logic [31:0] w, input int k);
    return int'((w >> (8 * k)) & 32'hFF);
  endfunction

  function automatic bit model_misaligned(input logic [2:0] sz, input int a);
    return (sz == SZ_HALF && (a % 2) != 0) || (sz == SZ_WORD && a != 0);
  endfunction

  // Enabled lanes are the byte range [lo,hi] touched by the access.
  function automatic logic [3:0] model_be(input logic [2:0] sz, input int a);
    int lo;
    int hi;
    logic [3:0] be;
    be = '0;
    case (sz)
      SZ_BYTE: begin lo = a; hi = a;     end
      SZ_HALF: begin lo = a; hi = a + 1; end
      SZ_WORD: begin lo = 0; hi = 3;     end
      SZ_LEFT: begin lo = 0; hi = a;     end
      default: begin lo = a; hi = 3;     end
    endcase
    for (int i = 0; i < 4; i++) be[i] = (i >= lo && i <= hi);
    return be;
  endfunction

  function automatic logic [31:0] model_wrdata(input logic [2:0] sz, input int a, input logic [31:0] d);
    logic [31:0] r;
    int b;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      case (sz)
        SZ_BYTE: b = byte_of(d, 0);
        SZ_HALF: b = byte_of(d, i % 2);
        SZ_WORD: b = byte_of(d, i);
        SZ_LEFT: b = (i <= a) ? byte_of(d, i + 3 - a) : 0;
        default: b = (i >= a) ? byte_of(d, i - a) : 0;
      endcase
      r = r | (32'(b) << (8 * i));
    end
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] sz, input int a, input logic [31:0] m,
                                             input logic [31:0] rt, input bit uns);
    logic [31:0] r;
    int v;
    int h;
    r = '0;
    case (sz)
      SZ_BYTE: begin
        v = byte_of(m, a);
        if (!uns && v >= 128) v = v - 256;
        r = 32'(v);
      end
      SZ_HALF: begin
        h = (a / 2) * 2;
        v = byte_of(m, h) + 256 * byte_of(m, h + 1);
        if (!uns && v >= 32768) v = v - 65536;
        r = 32'(v);
      end
      SZ_WORD: r = m;
      SZ_LEFT:
        for (int j = 0; j < 4; j++)
          r = r | (32'((j >= 3 - a) ? byte_of(m, j - (3 - a)) : byte_of(rt, j)) << (8 * j));
      default:
        for (int j = 0; j < 4; j++)
          r = r | (32'((j <= 3 - a) ? byte_of(m, j + a) : byte_of(rt, j)) << (8 * j));
    endcase
    return r;
  endfunction

  task automatic present_marker();
    mem_access_op = OP_D2R;
    reg_addr_i    = MARK_REG;
    data_i        = MARK_DATA;
  endtask

  // flush_at: REQ cycle index to flush in, ack_dly+1 flushes in DONE, -1 none.
  // rst_at: REQ cycle index to assert reset in, -1 none.
  task automatic run_access(input logic [1:0] op, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] d, input logic [4:0] rd, input bit uns,
                            input logic [31:0] rdata, input int ack_dly, input int flush_at,
                            input int rst_at);
    int a;
    bit ld;
    bit st;
    int stall_cnt;
    bit flushed;
    a  = int'(addr[1:0]);
    ld = (op == OP_M2R);
    st = (op == OP_R2M);
    flushed = (flush_at >= 0 && flush_at <= ack_dly);
    @(posedge clk); #1;
    mem_access_op = op; mem_access_sz = sz; mem_addr = addr; data_i = d;
    reg_addr_i = rd; flag_unsigned = uns; bus_ack = 1'b0; exception_flush = 1'b0;
    #1;
    if (!ld && !st) begin
      check_eq("d2r_data", data_o, d);
      check_eq("d2r_reg", 32'(reg_addr_o), 32'(rd));
      check_eq("d2r_stall", 32'(stall), 32'd0);
      return;
    end
    if (model_misaligned(sz, a)) begin
      check_eq("mis_err_load", 32'(addr_err_load), 32'(ld));
      check_eq("mis_err_store", 32'(addr_err_store), 32'(st));
      check_eq("mis_bad_vaddr", bad_vaddr, addr);
      check_eq("mis_stall", 32'(stall), 32'd0);
      check_eq("mis_reg", 32'(reg_addr_o), 32'd0);
      check_eq("mis_data", data_o, 32'd0);
      @(posedge clk); #1;
      check_eq("mis_no_bus", 32'({bus_read, bus_write}), 32'd0);
      return;
    end
    check_eq("idle_stall", 32'(stall), 32'd1);
    check_eq("idle_err", 32'({addr_err_load, addr_err_store}), 32'd0);
    stall_cnt = 1;
    for (int c = 0; c <= ack_dly; c++) begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      exception_flush = 1'b0;
      if (flushed && c > flush_at) present_marker();
      #1;
      check_eq("req_read", 32'(bus_read), 32'(ld));
      check_eq("req_write", 32'(bus_write), 32'(st));
      check_eq("req_addr", bus_address, {addr[31:2], 2'b00});
      check_eq("req_be", 32'(bus_byteenable), 32'(model_be(sz, a)));
      if (st) check_eq("req_wrdata", bus_wrdata, model_wrdata(sz, a, d));
      check_eq("req_stall", 32'(stall), 32'd1);
      check_eq("req_reg", 32'(reg_addr_o), 32'd0);
      stall_cnt++;
      if (c == rst_at) begin
        rst = 1'b1;
        mem_access_op = OP_D2R;
        reg_addr_i = '0;
        @(posedge clk); #1;
        check_eq("rst_rd_wr", 32'({bus_read, bus_write}), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_be", 32'(bus_byteenable), 32'd0);
        check_eq("rst_addr", bus_address, 32'd0);
        rst = 1'b0;
        return;
      end
      if (c == flush_at) exception_flush = 1'b1;
      if (c == ack_dly) begin
        bus_ack = 1'b1;
        bus_rddata = rdata;
      end
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    exception_flush = 1'b0;
    bus_rddata = $urandom;
    if (flushed) begin
      present_marker();
      #1;
      check_eq("flush_rd_wr", 32'({bus_read, bus_write}), 32'd0);
      check_eq("flush_stall", 32'(stall), 32'd0);
      check_eq("flush_next_reg", 32'(reg_addr_o), 32'(MARK_REG));
      check_eq("flush_next_data", data_o, MARK_DATA);
      return;
    end
    if (flush_at == ack_dly + 1) exception_flush = 1'b1;
    #1;
    check_eq("done_rd_wr", 32'({bus_read, bus_write}), 32'd0);
    check_eq("done_stall", 32'(stall), 32'd0);
    check_eq("stall_cycles", 32'(stall_cnt), 32'(ack_dly + 2));
    if (ld && !exception_flush) begin
      check_eq("done_data", data_o, model_load(sz, a, rdata, d, uns));
      check_eq("done_reg", 32'(reg_addr_o), 32'(rd));
    end else begin
      check_eq("done_data_none", data_o, 32'd0);
      check_eq("done_reg_none", 32'(reg_addr_o), 32'd0);
    end
    @(posedge clk); #1;
    exception_flush = 1'b0;
    present_marker();
    #1;
    check_eq("post_reg", 32'(reg_addr_o), 32'(MARK_REG));
    check_eq("post_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [2:0]  sz;
    int          dly;
    int          fa;
    int          ra;
    int          pick;
    rst = 1'b1; exception_flush = 1'b0; mem_access_op = OP_D2R; mem_access_sz = SZ_WORD;
    mem_addr = '0; data_i = '0; reg_addr_i = '0; flag_unsigned = 1'b0;
    bus_rddata = '0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_rd_wr", 32'({bus_read, bus_write}), 32'd0);
    check_eq("reset_be", 32'(bus_byteenable), 32'd0);
    check_eq("reset_addr", bus_address, 32'd0);
    check_eq("reset_wrdata", bus_wrdata, 32'd0);
    check_eq("reset_stall", 32'(stall), 32'd0);
    check_eq("reset_err", 32'({addr_err_load, addr_err_store}), 32'd0);
    rst = 1'b0;

    run_access(OP_R2M, SZ_BYTE,  32'h0000_1003, 32'h0000_00AB, 5'd3, 1'b0, 32'h0,         0, -1, -1);
    run_access(OP_M2R, SZ_BYTE,  32'h0000_2002, 32'h0,         5'd4, 1'b0, 32'h80FF_1234, 0, -1, -1);
    run_access(OP_M2R, SZ_BYTE,  32'h0000_2003, 32'h0,         5'd5, 1'b1, 32'h80FF_1234, 1, -1, -1);
    run_access(OP_M2R, SZ_LEFT,  32'h0000_4001, 32'h1122_3344, 5'd6, 1'b0, 32'hAABB_CCDD, 0, -1, -1);
    run_access(OP_M2R, SZ_RIGHT, 32'h0000_4002, 32'h1122_3344, 5'd7, 1'b0, 32'hAABB_CCDD, 2, -1, -1);
    run_access(OP_R2M, SZ_LEFT,  32'h0000_4000, 32'h1122_3344, 5'd8, 1'b0, 32'h0,         0, -1, -1);
    run_access(OP_M2R, SZ_WORD,  32'h0000_3002, 32'h0,         5'd9, 1'b0, 32'h0,         0, -1, -1);
    run_access(OP_M2R, SZ_WORD,  32'h0000_5000, 32'h0,         5'd10, 1'b0, 32'hCAFE_F00D, 5, -1, -1);
    run_access(OP_M2R, SZ_WORD,  32'h0000_6000, 32'h0,         5'd11, 1'b0, 32'h1234_5678, 4, 1, -1);
    run_access(OP_M2R, SZ_HALF,  32'h0000_7002, 32'h0,         5'd12, 1'b0, 32'h8001_0203, 4, -1, 1);

    for (int it = 0; it < 200; it++) begin
      pick = $urandom_range(0, 2);
      op  = (pick == 0) ? OP_D2R : (pick == 1) ? OP_M2R : OP_R2M;
      sz  = 3'($urandom_range(0, 4));
      dly = $urandom_range(0, 4);
      fa  = -1;
      ra  = -1;
      pick = $urandom_range(0, 7);
      if (pick == 0) fa = $urandom_range(0, dly + 1);
      else if (pick == 1) ra = $urandom_range(0, dly);
      run_access(op, sz, $urandom, $urandom, 5'($urandom_range(1, 29)), 1'($urandom),
                 $urandom, dly, fa, ra);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
